// File: rtl/dmem_responder.sv
// Single-port data-memory responder: valid/ready request in, fixed-latency word access, valid/ready response out.
// Optional macro DMEM_MISALIGN_CHECK_EN flags and suppresses accesses whose address is not word aligned.
//
// state  | meaning
// S_IDLE | ready for a request (req_ready=1)
// S_WAIT | request latched, timer counting down to the access edge
// S_RESP | response presented (rsp_valid=1) until the initiator takes it
module dmem_responder #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W   = ADDR_W - 2;
  localparam int unsigned DEPTH   = 2 ** IDX_W;
  localparam logic [3:0]  LAT_CNT = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]        cnt_q;
  logic              lat_we;
  logic [IDX_W-1:0]  lat_idx;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic accept;
  logic access;
  logic access_ok;
  logic mem_wr;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = (state_q == S_IDLE) & req_valid;
  assign access = (state_q == S_WAIT) & (cnt_q == 4'd0);
  assign mem_wr = access & access_ok & lat_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Timer is loaded on accept and counts down; the access happens on the terminal-count edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 4'd0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      cnt_q     <= LAT_CNT;
      lat_we    <= req_we;
      lat_idx   <= req_addr[ADDR_W-1:2];
      lat_wdata <= req_wdata;
    end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Write responses and suppressed accesses both return zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (access) begin
      if (lat_we || !access_ok) rdata_q <= '0;
      else                      rdata_q <= mem[lat_idx];
    end
  end

  // Array has no reset so it maps onto plain RAM; reset holds the FSM idle, so no stray writes.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[lat_idx] <= lat_wdata;
  end

  assign rsp_rdata = rdata_q;

`ifdef DMEM_MISALIGN_CHECK_EN
  logic [1:0] lat_lo;
  logic       err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_lo <= 2'b00;
      err_q  <= 1'b0;
    end else begin
      if (accept) lat_lo <= req_addr[1:0];
      if (access) err_q  <= |lat_lo;
    end
  end

  assign access_ok = ~|lat_lo;
  assign rsp_err   = err_q;
`else
  logic addr_lo_unused;

  assign addr_lo_unused = ^req_addr[1:0];
  assign access_ok      = 1'b1;
  assign rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: reset, table vectors, random traffic against a word-array model, corner sequences.
module tb_dmem_responder;

  localparam int LAT = 2;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        r0_valid, r0_ready, r0_we;
  logic [11:0] r0_addr;
  logic [31:0] r0_wdata;
  logic        r0_rsp_valid, r0_rsp_ready, r0_rsp_err;
  logic [31:0] r0_rsp_rdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] mm [1024];
  bit          wr [1024];

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(32), .ADDR_W(12), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DATA_W(32), .ADDR_W(12), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r0_valid), .req_ready(r0_ready), .req_we(r0_we),
    .req_addr(r0_addr), .req_wdata(r0_wdata),
    .rsp_valid(r0_rsp_valid), .rsp_ready(r0_rsp_ready),
    .rsp_rdata(r0_rsp_rdata), .rsp_err(r0_rsp_err)
  );

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full transaction: wait for ready, accept, scramble inputs, time the response, handshake it.
  task automatic do_txn(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err);
    int n;
    req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    check("req_ready before accept", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wd;
    n = 0;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    check("response latency", n, LAT + 1);
    rd  = rsp_rdata;
    err = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("idle after handshake", {30'd0, req_ready, rsp_valid}, 32'd2);
    check("rdata kept after handshake", rsp_rdata, rd);
  endtask

  // Reference: word array indexed by addr[11:2]; misaligned access suppressed only when the check is built in.
  task automatic model_txn(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                           output logic [31:0] exp_rd, output logic exp_err, output bit known);
    int idx;
    idx     = int'(addr) / 4;
    exp_err = MIS && (addr % 4 != 0);
    known   = 1'b1;
    exp_rd  = 32'd0;
    if (!exp_err) begin
      if (we) begin
        mm[idx] = wd;
        wr[idx] = 1'b1;
      end else if (wr[idx]) begin
        exp_rd = mm[idx];
      end else begin
        known = 1'b0;
      end
    end
  endtask

  initial begin
    vec_t        vt[$];
    logic [31:0] rd, erd, stable;
    logic        err, eerr;
    bit          known;

    for (int i = 0; i < 1024; i++) begin mm[i] = 32'd0; wr[i] = 1'b0; end
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    r0_valid = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0; r0_rsp_ready = 0;
    rst_n = 1'b0;

    vt.push_back('{1'b1, 12'h010, 32'hDEADBEEF, 32'h0});
    vt.push_back('{1'b0, 12'h010, 32'h0,        32'hDEADBEEF});
    vt.push_back('{1'b1, 12'h020, 32'h22222222, 32'h0});
    vt.push_back('{1'b1, 12'h014, 32'h12345678, 32'h0});
    vt.push_back('{1'b0, 12'h020, 32'h0,        32'h22222222});
    vt.push_back('{1'b0, 12'h014, 32'h0,        32'h12345678});
    vt.push_back('{1'b1, 12'hFFC, 32'hCAFEF00D, 32'h0});
    vt.push_back('{1'b1, 12'h000, 32'h00000001, 32'h0});
    vt.push_back('{1'b0, 12'hFFC, 32'h0,        32'hCAFEF00D});
    vt.push_back('{1'b0, 12'h000, 32'h0,        32'h00000001});

    // Reset values, then FSM stays idle after release.
    tick(); tick();
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("idle after release", {30'd0, req_ready, rsp_valid}, 32'd2);

    foreach (vt[i]) begin
      do_txn(vt[i].we, vt[i].addr, vt[i].wdata, rd, err);
      model_txn(vt[i].we, vt[i].addr, vt[i].wdata, erd, eerr, known);
      check($sformatf("vec%0d rdata", i), rd, vt[i].exp_rdata);
      check($sformatf("vec%0d err", i), {31'd0, err}, 32'd0);
    end

    // Response held while the initiator stalls; a pending request is not taken.
    req_we = 1'b0; req_addr = 12'h010; req_valid = 1'b1;
    tick();
    req_addr = 12'h014;
    for (int i = 0; i < LAT + 1; i++) tick();
    check("stall rsp_valid up", {31'd0, rsp_valid}, 32'd1);
    stable = rsp_rdata;
    check("stall rdata", stable, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall hold", {30'd0, rsp_valid, req_ready}, 32'd2);
      check("stall rdata stable", rsp_rdata, stable);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("stall release idle", {30'd0, req_ready, rsp_valid}, 32'd2);

    // Uncommitted write discarded by reset in WAIT.
    req_we = 1'b1; req_addr = 12'h020; req_wdata = 32'h11111111; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #2;
    check("async reset ready", {30'd0, req_ready, rsp_valid}, 32'd2);
    rst_n = 1'b1;
    tick();
    do_txn(1'b0, 12'h020, 32'h0, rd, err);
    check("write aborted by reset", rd, 32'h22222222);

    // Misaligned access.
    do_txn(1'b1, 12'h010, 32'hA5A5A5A5, rd, err);
    model_txn(1'b1, 12'h010, 32'hA5A5A5A5, erd, eerr, known);
    do_txn(1'b0, 12'h013, 32'h0, rd, err);
    check("misaligned read rdata", rd, MIS ? 32'h0 : 32'hA5A5A5A5);
    check("misaligned read err", {31'd0, err}, {31'd0, MIS});
    do_txn(1'b1, 12'h011, 32'h99999999, rd, err);
    model_txn(1'b1, 12'h011, 32'h99999999, erd, eerr, known);
    check("misaligned write err", {31'd0, err}, {31'd0, MIS});
    do_txn(1'b0, 12'h010, 32'h0, rd, err);
    check("after misaligned write", rd, MIS ? 32'hA5A5A5A5 : 32'h99999999);
    check("aligned clears err", {31'd0, err}, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 40; i++) begin
      logic        we;
      logic [11:0] addr;
      logic [31:0] wd;
      we   = 1'($urandom_range(0, 1));
      addr = 12'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) addr = addr | 12'($urandom_range(1, 3));
      wd   = $urandom;
      do_txn(we, addr, wd, rd, err);
      model_txn(we, addr, wd, erd, eerr, known);
      if (known) check($sformatf("rand%0d rdata", i), rd, erd);
      check($sformatf("rand%0d err", i), {31'd0, err}, {31'd0, eerr});
    end

    // Back-to-back with LATENCY=0: idle, wait, resp repeating; one-cycle rsp_valid pulses.
    r0_we = 1'b1; r0_addr = 12'h040; r0_wdata = 32'h5; r0_valid = 1'b1; r0_rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("stream cycle%0d", k), {30'd0, r0_ready, r0_rsp_valid},
            {30'd0, k % 3 == 0, k % 3 == 2});
      if (k % 3 == 2) check($sformatf("stream rdata%0d", k), r0_rsp_rdata, 32'd0);
      tick();
    end
    r0_valid = 1'b0;
    tick(); tick(); tick();
    check("stream idle", {30'd0, r0_ready, r0_rsp_valid}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
